// File: rtl/cva6_clic_irq_sync.sv
// Registered CLIC interrupt acceptance: qualifies the CLIC's best interrupt, holds it and
// hands it to the ID stage with a req/ack handshake. Optional SHV path: CVA6_CLIC_SHV_EN.
module cva6_clic_irq_sync #(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned NumSrc  = 256,
  parameter bit          SModeEn = 1'b1,
  parameter bit          UModeEn = 1'b1,
  localparam int unsigned IdW    = $clog2(NumSrc)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [1:0]      priv_lvl_i,
  input  logic            mie_i,
  input  logic            sie_i,
  input  logic [7:0]      mintthresh_i,
  input  logic [7:0]      sintthresh_i,
  input  logic [7:0]      mil_i,
  input  logic [7:0]      sil_i,
  input  logic            clic_irq_valid_i,
  input  logic [IdW-1:0]  clic_irq_id_i,
  input  logic [7:0]      clic_irq_level_i,
  input  logic [1:0]      clic_irq_priv_i,
`ifdef CVA6_CLIC_SHV_EN
  input  logic            clic_irq_shv_i,
  output logic            irq_shv_o,
`endif
  output logic            clic_irq_ready_o,
  output logic            irq_req_o,
  input  logic            irq_ack_i,
  output logic [XLEN-1:0] irq_cause_o,
  output logic [7:0]      irq_level_o,
  output logic [1:0]      irq_priv_o
);

  localparam logic [1:0] PrivU = 2'd0;
  localparam logic [1:0] PrivS = 2'd1;
  localparam logic [1:0] PrivM = 2'd3;

  typedef enum logic [1:0] {StIdle, StPend, StAck} state_e;

  state_e           state_q, state_d;
  logic             load;
  logic             qualify;
  logic             s_ok;
  logic [7:0]       mth, sth;
  logic [IdW-1:0]   id_q;
  logic [7:0]       level_q;
  logic [1:0]       priv_q;
`ifdef CVA6_CLIC_SHV_EN
  logic             shv_q;
`endif

  // Effective thresholds are the larger of the CSR threshold and the current interrupt level.
  always_comb begin
    mth     = (mintthresh_i > mil_i) ? mintthresh_i : mil_i;
    sth     = (sintthresh_i > sil_i) ? sintthresh_i : sil_i;
    s_ok    = SModeEn && (clic_irq_priv_i == PrivS) && sie_i;
    qualify = 1'b0;
    if (clic_irq_valid_i) begin
      case (priv_lvl_i)
        PrivM:   qualify = (clic_irq_priv_i == PrivM) && (clic_irq_level_i > mth) && mie_i;
        PrivS:   qualify = (clic_irq_priv_i == PrivM) || (s_ok && (clic_irq_level_i > sth));
        PrivU:   qualify = UModeEn && ((clic_irq_priv_i == PrivM) || s_ok);
        default: qualify = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      StIdle: begin
        if (qualify) begin
          load    = 1'b1;
          state_d = StPend;
        end
      end
      StPend: begin
        // Ack wins over re-arbitration so the acked interrupt is exactly what was presented.
        if (irq_ack_i) begin
          state_d = StAck;
        end else if (qualify) begin
          load = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      id_q    <= '0;
      level_q <= '0;
      priv_q  <= '0;
`ifdef CVA6_CLIC_SHV_EN
      shv_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (load) begin
        id_q    <= clic_irq_id_i;
        level_q <= clic_irq_level_i;
        priv_q  <= clic_irq_priv_i;
`ifdef CVA6_CLIC_SHV_EN
        shv_q   <= clic_irq_shv_i;
`endif
      end
    end
  end

  always_comb begin
    irq_cause_o           = '0;
    irq_cause_o[XLEN-1]   = 1'b1;
    irq_cause_o[23:16]    = level_q;
    irq_cause_o[IdW-1:0]  = id_q;
`ifdef CVA6_CLIC_SHV_EN
    irq_cause_o[30]       = shv_q;
`endif
  end

  assign irq_req_o        = (state_q == StPend);
  assign clic_irq_ready_o = (state_q == StAck);
  assign irq_level_o      = level_q;
  assign irq_priv_o       = priv_q;
`ifdef CVA6_CLIC_SHV_EN
  assign irq_shv_o        = shv_q;
`endif

endmodule

// File: doc/cva6_clic_irq_sync.md
Name: cva6_clic_irq_sync

Overview:
Registered, handshaked successor to the combinational CLIC acceptance logic. It sits between the CLIC and the ID stage and qualifies the CLIC's current best interrupt against privilege, enable and threshold state. It holds the accepted interrupt in a holding register and presents it to the ID stage with a req/ack handshake. On ack it returns a one-cycle ready pulse to the CLIC. It is generalised over XLEN, source count and supported privilege modes.

Parameters:
XLEN, 64, datapath width of irq_cause_o (32 or 64)
NumSrc, 256, number of CLIC sources; IdW = clog2(NumSrc), must be <= 16
SModeEn, 1, 0: S-priv interrupts never accepted; sie_i and sintthresh_i ignored
UModeEn, 1, 0: priv_lvl_i == U treated as illegal; never accept

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
priv_lvl_i  in  2  current privilege (M=3, S=1, U=0)
mie_i  in  1  mstatus.MIE
sie_i  in  1  mstatus.SIE
mintthresh_i  in  8  M threshold
sintthresh_i  in  8  S threshold
mil_i  in  8  mintstatus.mil
sil_i  in  8  mintstatus.sil
clic_irq_valid_i  in  1  CLIC presents an interrupt
clic_irq_id_i  in  IdW  interrupt ID
clic_irq_level_i  in  8  interrupt level
clic_irq_priv_i  in  2  interrupt target privilege
clic_irq_ready_o  out  1  one-cycle accept pulse to CLIC
irq_req_o  out  1  request to ID stage
irq_ack_i  in  1  ID stage takes the interrupt (valid only while irq_req_o=1)
irq_cause_o  out  XLEN  packed cause
irq_level_o  out  8  held level
irq_priv_o  out  2  held target privilege

Behaviour:
- qualify(x), combinational, on the current CLIC inputs. Result is 0 if valid=0.
  - mth = max(mintthresh_i, mil_i); sth = max(sintthresh_i, sil_i).
  - priv M: accept iff clic priv==M, level > mth and mie_i.
  - priv S: clic priv M always accepted; clic priv S iff level > sth and sie_i.
  - priv U: clic priv M always accepted; clic priv S iff sie_i.
  - clic priv U or 2: never accepted.
  - SModeEn=0: clic priv S never accepted. UModeEn=0: priv_lvl_i==U gives 0. priv_lvl_i==2: 0.
- FSM states IDLE, PEND, ACK.
  - IDLE: if qualify, load holding regs (id, level, priv) and go to PEND.
  - PEND: irq_ack_i takes priority and goes to ACK; holding regs are frozen.
  - PEND, else if qualify: reload holding regs from the current inputs (tracks CLIC arbitration changes) and stay in PEND.
  - PEND, else (withdrawn, threshold raised, enable cleared, priv change): go to IDLE.
  - ACK: clic_irq_ready_o=1 for exactly this cycle. No capture. Next state IDLE unconditionally.
- Outputs:
  - irq_req_o = (state==PEND), registered.
  - Latency: qualify in cycle t gives irq_req_o=1 in cycle t+1. Ack in t gives ready in t+1 and earliest new req in t+3.
- irq_cause_o, driven from holding regs:
  - bit XLEN-1 = 1; bits XLEN-2..24 = 0; bits 23..16 = level; bits 15..IdW = 0; bits IdW-1..0 = id.
- irq_ack_i in IDLE or ACK: ignored, no state change.
- Reset (synchronous): state IDLE, holding regs 0. Outputs: irq_req_o=0, clic_irq_ready_o=0, irq_cause_o = 1 in bit XLEN-1 and 0 elsewhere, irq_level_o=0, irq_priv_o=0.
  - Reset mid-PEND or mid-ACK: the ready pulse is suppressed and the pending request is dropped.

Optional Feature:
CVA6_CLIC_SHV_EN
- Defined: adds clic_irq_shv_i (in, 1) and irq_shv_o (out, 1). The SHV bit is held and reloaded with the other holding regs. It resets to 0. It is also copied into irq_cause_o bit 30, which is reserved-zero without the macro.
- Undefined: ports absent; bit 30 = 0.

Test Plan:
- priv M, mie=1, mth=max(0x20,0x10), irq id 5 level 0x40 priv M -> next cycle irq_req_o=1, irq_cause_o=0x8000_0000_0040_0005 (XLEN 64).
- priv M, level 0x20, mintthresh 0x20 -> never requested (strict >); raising level to 0x21 -> req after 1 cycle.
- PEND with id 5; CLIC switches to id 9 level 0x80 -> holding updates to 9 with req held high. Then valid drops -> req low next cycle.
- Ack in PEND while the input changes in the same cycle -> cause frozen at the acked value, ready=1 next cycle for 1 cycle, req low until t+3.
- priv S, sie=0, S-priv irq -> no req; M-priv irq with mie=0 -> req. Repeat with SModeEn=0: S-priv is never requested regardless of sie.
- Assert rst_i during ACK -> ready_o=0 in the following cycle and all outputs at reset values.
